yutorina_id_hazard_stage: RTL and testbench
===========================================

// Module: yutorina_id_hazard_stage
// PURPOSE
//  Parametrised decode-stage operand/pipeline block: N-source priority forwarding,
//  load-use interlock FSM with configurable load latency, stall/flush handling and
//  an interlock-cycle counter. Sits between IF and EX beside the insn decoder; it
//  supplies forwarded operands to the decoder and registers the decoded bundle.
// PARAMETERS
//  DATA_W    32  operand/GPR data width
//  GPR_AW     5  GPR address width; address 0 reads as zero, is never forwarded
//  FWD_N      2  forwarding sources; index 0 = youngest = highest priority
//  BUNDLE_W  64  width of opaque decoded bundle (alu op, mem op, ctrl op, wr addr...)
//  LOAD_LAT   1  bubbles inserted per load-use hazard (>=1)
//  CNT_W     16  interlock counter width
// PORTS
//  clk          in   1                clock
//  rst          in   1                async reset, active-high
//  stall        in   1                pipeline hold from ctrl
//  flush        in   1                kill ID contents (priority over stall)
//  if_en_       in   1                IF valid, active-low
//  dec_r_addr1  in   GPR_AW           decoder source 1 address
//  dec_r_addr2  in   GPR_AW           decoder source 2 address
//  dec_use1     in   1                source 1 actually read
//  dec_use2     in   1                source 2 actually read
//  dec_bundle   in   BUNDLE_W         decoded fields for EX
//  gpr_r_data1  in   DATA_W           register file port 1
//  gpr_r_data2  in   DATA_W           register file port 2
//  fwd_vld      in   FWD_N            source i writes a GPR
//  fwd_ld       in   FWD_N            source i is a load whose data is not ready
//  fwd_addr     in   FWD_N*GPR_AW     packed dest addresses, slice i = source i
//  fwd_data     in   FWD_N*DATA_W     packed result data
//  r_data1      out  DATA_W           forwarded operand 1 (comb, to decoder)
//  r_data2      out  DATA_W           forwarded operand 2 (comb)
//  if_hold      out  1                interlock: IF must hold current insn
//  id_en_       out  1                ID output valid, active-low
//  id_bundle    out  BUNDLE_W         registered bundle
//  id_r_data1   out  DATA_W           registered operand 1
//  id_r_data2   out  DATA_W           registered operand 2
//  intlk_cnt    out  CNT_W            saturating count of interlock bubbles
// BEHAVIOUR
//  Forwarding (comb): addr==0 -> 0; else lowest i with fwd_vld[i] && fwd_addr[i]==addr
//   -> fwd_data[i]; else gpr_r_data. Only the winning source is considered.
//  hazard = !if_en_ && state==RUN && ((dec_use1 && win1 is ld) || (dec_use2 && win2 is ld)).
//  if_hold = hazard || state==LOCK (comb; asserted regardless of stall).
//  FSM RUN/LOCK, down-counter lat_cnt (width clog2(LOAD_LAT)+1). Per edge, priority:
//   1 rst: id_en_=1, id_bundle=0, id_r_data1/2=0, intlk_cnt=0, RUN, lat_cnt=0.
//   2 flush: id_en_<=1, state<=RUN, lat_cnt<=0; data regs and intlk_cnt hold.
//   3 stall: every register incl. FSM, lat_cnt, intlk_cnt holds.
//   4 RUN, hazard: id_en_<=1 (bubble), intlk_cnt++; LOAD_LAT>1 -> LOCK, lat_cnt<=LOAD_LAT-1.
//   5 RUN, !if_en_, no hazard: capture dec_bundle, r_data1/2; id_en_<=0.
//   6 RUN, if_en_ high: id_en_<=1, data regs hold.
//   7 LOCK: id_en_<=1, intlk_cnt++, lat_cnt--; lat_cnt==1 -> RUN. No hazard check in LOCK.
//  Total bubbles per hazard = LOAD_LAT; after return to RUN hazard is re-evaluated.
//  intlk_cnt saturates at all-ones; never wraps. Stall/flush cycles not counted.
//  Latency: 1 cycle IF->ID outputs when no hazard. Reset mid-LOCK -> RUN at once.
// TESTING
//  Priority: addr1=3, fwd0(3,0x11), fwd1(3,0x22) valid, gpr=0x33 -> r_data1=0x11; drop fwd0
//   -> 0x22; drop both -> 0x33; addr1=0 with fwd0 addr 0 -> 0.
//  Load-use LOAD_LAT=2: fwd0 addr5 ld=1, dec_use1, addr1=5 -> if_hold 2 cycles, id_en_=1
//   2 cycles, 3rd edge captures fwd data 0xAB, id_en_=0, intlk_cnt=2.
//  Unused operand: same as above with dec_use1=0 -> no hold, capture next edge.
//  Stall in LOCK: LOAD_LAT=3, stall 3 cycles after first bubble -> lat_cnt/outputs frozen,
//   intlk_cnt ends 3, exactly 3 bubbles.
//  Flush in LOCK -> next cycle RUN, id_en_=1, if_hold low if no new hazard; rst mid-LOCK
//   -> all outputs at reset values asynchronously.
//  CNT_W=4, 20 hazards with LOAD_LAT=1 -> intlk_cnt stays 15.

Source files
------------

// File: rtl/yutorina_id_hazard_stage.sv
// ============================================================================
// Module   : yutorina_id_hazard_stage
// Purpose  : ID-stage operand forwarding, load-use interlock and ID register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module yutorina_id_hazard_stage #(
  parameter int DATA_W   = 32,
  parameter int GPR_AW   = 5,
  parameter int FWD_N    = 2,
  parameter int BUNDLE_W = 64,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    if_en_,
  input  logic [GPR_AW-1:0]       dec_r_addr1,
  input  logic [GPR_AW-1:0]       dec_r_addr2,
  input  logic                    dec_use1,
  input  logic                    dec_use2,
  input  logic [BUNDLE_W-1:0]     dec_bundle,
  input  logic [DATA_W-1:0]       gpr_r_data1,
  input  logic [DATA_W-1:0]       gpr_r_data2,
  input  logic [FWD_N-1:0]        fwd_vld,
  input  logic [FWD_N-1:0]        fwd_ld,
  input  logic [FWD_N*GPR_AW-1:0] fwd_addr,
  input  logic [FWD_N*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]       r_data1,
  output logic [DATA_W-1:0]       r_data2,
  output logic                    if_hold,
  output logic                    id_en_,
  output logic [BUNDLE_W-1:0]     id_bundle,
  output logic [DATA_W-1:0]       id_r_data1,
  output logic [DATA_W-1:0]       id_r_data2,
  output logic [CNT_W-1:0]        intlk_cnt
);

  localparam int LAT_W = $clog2(LOAD_LAT) + 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);

  typedef enum logic [0:0] {RUN = 1'b0, LOCK = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic               en_nxt;
  logic               capture;
  logic               count;
  logic               ld1, ld2;
  logic               hazard;

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    r_data1 = gpr_r_data1;
    r_data2 = gpr_r_data2;
    ld1     = 1'b0;
    ld2     = 1'b0;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (fwd_vld[i] && fwd_addr[i*GPR_AW +: GPR_AW] == dec_r_addr1) begin
        r_data1 = fwd_data[i*DATA_W +: DATA_W];
        ld1     = fwd_ld[i];
      end
      if (fwd_vld[i] && fwd_addr[i*GPR_AW +: GPR_AW] == dec_r_addr2) begin
        r_data2 = fwd_data[i*DATA_W +: DATA_W];
        ld2     = fwd_ld[i];
      end
    end
    if (dec_r_addr1 == '0) begin
      r_data1 = '0;
      ld1     = 1'b0;
    end
    if (dec_r_addr2 == '0) begin
      r_data2 = '0;
      ld2     = 1'b0;
    end
  end

  assign hazard  = !if_en_ && (state == RUN) && ((dec_use1 && ld1) || (dec_use2 && ld2));
  assign if_hold = hazard || (state == LOCK);

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    en_nxt    = id_en_;
    capture   = 1'b0;
    count     = 1'b0;
    if (flush) begin
      state_nxt = RUN;
      lat_nxt   = '0;
      en_nxt    = 1'b1;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (hazard) begin
            en_nxt = 1'b1;
            count  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LOCK;
              lat_nxt   = LAT_INIT;
            end
          end else if (!if_en_) begin
            capture = 1'b1;
            en_nxt  = 1'b0;
          end else begin
            en_nxt = 1'b1;
          end
        end
        LOCK: begin
          en_nxt  = 1'b1;
          count   = 1'b1;
          lat_nxt = lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      lat_cnt <= '0;
      id_en_  <= 1'b1;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      id_en_  <= en_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_bundle  <= '0;
      id_r_data1 <= '0;
      id_r_data2 <= '0;
      intlk_cnt  <= '0;
    end else begin
      if (capture) begin
        id_bundle  <= dec_bundle;
        id_r_data1 <= r_data1;
        id_r_data2 <= r_data2;
      end
      // Saturate rather than wrap so the count stays a lower bound.
      if (count && intlk_cnt != {CNT_W{1'b1}}) intlk_cnt <= intlk_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_yutorina_id_hazard_stage.sv
// ============================================================================
// Module   : tb_yutorina_id_hazard_stage
// Purpose  : Bench for yutorina_id_hazard_stage across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yutorina_id_hazard_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, if_en_;
  logic [4:0]  dec_r_addr1, dec_r_addr2;
  logic        dec_use1, dec_use2;
  logic [63:0] dec_bundle;
  logic [31:0] gpr_r_data1, gpr_r_data2;
  logic [1:0]  fwd_vld, fwd_ld;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;

  logic [31:0] a_rd1, a_rd2, a_id1, a_id2, b_rd1, b_rd2, b_id1, b_id2, c_rd1, c_rd2, c_id1, c_id2;
  logic        a_hold, a_en_, b_hold, b_en_, c_hold, c_en_;
  logic [63:0] a_bun, b_bun, c_bun;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  always #5 clk = ~clk;

  yutorina_id_hazard_stage #(.LOAD_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_en_(if_en_),
    .dec_r_addr1(dec_r_addr1), .dec_r_addr2(dec_r_addr2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_bundle(dec_bundle), .gpr_r_data1(gpr_r_data1), .gpr_r_data2(gpr_r_data2),
    .fwd_vld(fwd_vld), .fwd_ld(fwd_ld), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .r_data1(a_rd1), .r_data2(a_rd2), .if_hold(a_hold), .id_en_(a_en_), .id_bundle(a_bun),
    .id_r_data1(a_id1), .id_r_data2(a_id2), .intlk_cnt(a_cnt));

  yutorina_id_hazard_stage #(.LOAD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_en_(if_en_),
    .dec_r_addr1(dec_r_addr1), .dec_r_addr2(dec_r_addr2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_bundle(dec_bundle), .gpr_r_data1(gpr_r_data1), .gpr_r_data2(gpr_r_data2),
    .fwd_vld(fwd_vld), .fwd_ld(fwd_ld), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .r_data1(b_rd1), .r_data2(b_rd2), .if_hold(b_hold), .id_en_(b_en_), .id_bundle(b_bun),
    .id_r_data1(b_id1), .id_r_data2(b_id2), .intlk_cnt(b_cnt));

  yutorina_id_hazard_stage #(.LOAD_LAT(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_en_(if_en_),
    .dec_r_addr1(dec_r_addr1), .dec_r_addr2(dec_r_addr2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_bundle(dec_bundle), .gpr_r_data1(gpr_r_data1), .gpr_r_data2(gpr_r_data2),
    .fwd_vld(fwd_vld), .fwd_ld(fwd_ld), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .r_data1(c_rd1), .r_data2(c_rd2), .if_hold(c_hold), .id_en_(c_en_), .id_bundle(c_bun),
    .id_r_data1(c_id1), .id_r_data2(c_id2), .intlk_cnt(c_cnt));

  typedef struct {
    logic [4:0]  a1, a2;
    logic [1:0]  vld;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1, g1, g2;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0h, no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, act, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; if_en_ = 1'b1;
    dec_r_addr1 = '0; dec_r_addr2 = '0; dec_use1 = 1'b0; dec_use2 = 1'b0;
    dec_bundle = 64'hDEAD_BEEF_0123_4567; gpr_r_data1 = 32'h33; gpr_r_data2 = 32'h44;
    fwd_vld = '0; fwd_ld = '0; fwd_addr = '0; fwd_data = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Load on fwd source 0 targeting r5, consumed on source 1.
  task automatic set_load(input logic use1, input logic ld);
    if_en_ = 1'b0; dec_use1 = use1; dec_r_addr1 = 5'd5;
    fwd_vld = 2'b01; fwd_ld = {1'b0, ld}; fwd_addr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'hAB};
  endtask

  initial begin
    vecs[0] = '{a1:3, a2:7, vld:2'b11, fa0:3, fa1:3, fd0:32'h11, fd1:32'h22, g1:32'h33, g2:32'h44, e1:32'h11, e2:32'h44};
    vecs[1] = '{a1:3, a2:7, vld:2'b10, fa0:3, fa1:3, fd0:32'h11, fd1:32'h22, g1:32'h33, g2:32'h44, e1:32'h22, e2:32'h44};
    vecs[2] = '{a1:3, a2:7, vld:2'b00, fa0:3, fa1:3, fd0:32'h11, fd1:32'h22, g1:32'h33, g2:32'h44, e1:32'h33, e2:32'h44};
    vecs[3] = '{a1:0, a2:7, vld:2'b01, fa0:0, fa1:3, fd0:32'h11, fd1:32'h22, g1:32'h33, g2:32'h44, e1:32'h0,  e2:32'h44};
    vecs[4] = '{a1:4, a2:3, vld:2'b11, fa0:4, fa1:3, fd0:32'h55, fd1:32'h66, g1:32'h33, g2:32'h44, e1:32'h55, e2:32'h66};
    vecs[5] = '{a1:9, a2:0, vld:2'b11, fa0:8, fa1:0, fd0:32'h77, fd1:32'h88, g1:32'h99, g2:32'hAA, e1:32'h99, e2:32'h0};

    do_reset();
    expect_val(64'h1); check("reset id_en_", {63'h0, a_en_});
    expect_val(64'h0); check("reset id_bundle", a_bun);
    expect_val(64'h0); check("reset intlk_cnt", {48'h0, a_cnt});
    expect_val(64'h0); check("reset if_hold", {63'h0, a_hold});

    for (int i = 0; i < 6; i++) begin
      dec_r_addr1 = vecs[i].a1; dec_r_addr2 = vecs[i].a2; fwd_vld = vecs[i].vld;
      fwd_addr = {vecs[i].fa1, vecs[i].fa0}; fwd_data = {vecs[i].fd1, vecs[i].fd0};
      gpr_r_data1 = vecs[i].g1; gpr_r_data2 = vecs[i].g2;
      expect_val({32'h0, vecs[i].e1});
      expect_val({32'h0, vecs[i].e2});
      #1;
      check($sformatf("fwd vec%0d r_data1", i), {32'h0, a_rd1});
      check($sformatf("fwd vec%0d r_data2", i), {32'h0, a_rd2});
    end

    // Load-use, LOAD_LAT=2 (dut_a)
    do_reset();
    set_load(1'b1, 1'b1);
    #1; expect_val(64'h1); check("lu hazard if_hold", {63'h0, a_hold});
    tick();
    expect_val(64'h1); check("lu bubble1 id_en_", {63'h0, a_en_});
    fwd_ld = 2'b00; #1;
    expect_val(64'h1); check("lu lock if_hold", {63'h0, a_hold});
    tick();
    expect_val(64'h1); check("lu bubble2 id_en_", {63'h0, a_en_});
    expect_val(64'h0); check("lu run if_hold", {63'h0, a_hold});
    tick();
    expect_val(64'h0); check("lu capture id_en_", {63'h0, a_en_});
    expect_val(64'hAB); check("lu capture data1", {32'h0, a_id1});
    expect_val(64'hDEAD_BEEF_0123_4567); check("lu capture bundle", a_bun);
    expect_val(64'h2); check("lu intlk_cnt", {48'h0, a_cnt});

    // Unused operand: no interlock
    do_reset();
    set_load(1'b0, 1'b1);
    #1; expect_val(64'h0); check("unused if_hold", {63'h0, a_hold});
    tick();
    expect_val(64'h0); check("unused id_en_", {63'h0, a_en_});
    expect_val(64'hAB); check("unused data1", {32'h0, a_id1});
    expect_val(64'h0); check("unused intlk_cnt", {48'h0, a_cnt});

    // Stall in LOCK, LOAD_LAT=3 (dut_b)
    do_reset();
    set_load(1'b1, 1'b1);
    tick();
    fwd_ld = 2'b00; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_val(64'h1); check($sformatf("stall%0d intlk_cnt", k), {48'h0, b_cnt});
      expect_val(64'h1); check($sformatf("stall%0d if_hold", k), {63'h0, b_hold});
      expect_val(64'h1); check($sformatf("stall%0d id_en_", k), {63'h0, b_en_});
    end
    stall = 1'b0;
    tick();
    expect_val(64'h1); check("post-stall lock if_hold", {63'h0, b_hold});
    tick();
    expect_val(64'h0); check("post-stall run if_hold", {63'h0, b_hold});
    expect_val(64'h1); check("post-stall bubble3 id_en_", {63'h0, b_en_});
    tick();
    expect_val(64'h0); check("post-stall capture id_en_", {63'h0, b_en_});
    expect_val(64'h3); check("post-stall intlk_cnt", {48'h0, b_cnt});

    // Flush in LOCK (dut_b)
    do_reset();
    set_load(1'b1, 1'b1);
    tick();
    fwd_ld = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    expect_val(64'h1); check("flush id_en_", {63'h0, b_en_});
    expect_val(64'h0); check("flush if_hold", {63'h0, b_hold});
    expect_val(64'h1); check("flush intlk_cnt", {48'h0, b_cnt});

    // Async reset mid-LOCK (dut_b)
    do_reset();
    set_load(1'b1, 1'b0);
    tick();
    fwd_ld = 2'b01;
    tick();
    expect_val(64'h1); check("pre-rst lock if_hold", {63'h0, b_hold});
    #2; rst = 1'b1; if_en_ = 1'b1; #1;
    expect_val(64'h1); check("async rst id_en_", {63'h0, b_en_});
    expect_val(64'h0); check("async rst bundle", b_bun);
    expect_val(64'h0); check("async rst data1", {32'h0, b_id1});
    expect_val(64'h0); check("async rst intlk_cnt", {48'h0, b_cnt});
    expect_val(64'h0); check("async rst if_hold", {63'h0, b_hold});

    // Saturation, CNT_W=4, LOAD_LAT=1 (dut_c)
    do_reset();
    set_load(1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 20) begin
        expect_val(k == 14 ? 64'd14 : 64'd15);
        check($sformatf("sat after %0d", k), {60'h0, c_cnt});
      end
    end
    expect_val(64'h1); check("sat id_en_", {63'h0, c_en_});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
